// File: rtl/regfile_arbiter_pkg.sv
// regfile_arb_pkg: shared FSM encoding and constants for the register-file arbiter.
package regfile_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [7:0] TIMEOUT_DATA = 8'hEE;
    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: requester command/response bus plus register-file port.
//   req_*  : packed per-requester commands (valid/write/addr/wdata) and one-hot ready
//   rsp_*  : one-hot response strobe with shared read data and timeout flag
//   rf_*   : single register-file access port
//   slave  : arbiter view; master : requesters + register file view
interface regfile_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_timeout;
    logic                      rf_read;
    logic                      rf_write;
    logic [ADDR_W-1:0]         rf_address;
    logic [DATA_W-1:0]         rf_write_data;
    logic                      rf_done;
    logic [DATA_W-1:0]         rf_read_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rf_done, rf_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
               rf_read, rf_write, rf_address, rf_write_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rf_done, rf_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
               rf_read, rf_write, rf_address, rf_write_data
    );
endinterface

// File: rtl/regfile_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant.
//   req   : request vector
//   ptr   : highest-priority requester index
//   grant : one-hot grant (zero when no request)
//   idx   : binary index of the granted requester
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx
);
    // Walk from lowest priority (ptr+NUM_REQ-1) up to ptr; the last hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int p = NUM_REQ - 1; p >= 0; p--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && ((int'(ptr) + p) % NUM_REQ) == i) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    idx      = PTR_W'(i);
                end
            end
        end
    end
endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of one register-file port between NUM_REQ requesters.
//   clk, rst : register-file clock, synchronous active-high reset
//   bus      : requester commands/responses and register-file strobes (slave modport)
// Each transaction issues exactly one rf_read/rf_write cycle so FIFO reads pop once.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic              clk,
    input logic              rst,
    regfile_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t             state, state_d;
    logic [PTR_W-1:0]   ptr, owner, gidx;
    logic [NUM_REQ-1:0] grant;
    logic               wr_q, rsp_to, timed_out;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q, rdata_q;
    logic [7:0]         cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req  (bus.req_valid),
        .ptr  (ptr),
        .grant(grant),
        .idx  (gidx)
    );

    // A done on the final wait cycle takes precedence over the abort.
    assign timed_out = !bus.rf_done && cnt == TO_LAST;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d       = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rf_read   = 1'b0;
        bus.rf_write  = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = rst ? '0 : grant;
                state_d       = |bus.req_valid ? ISSUE : IDLE;
            end
            ISSUE: begin
                bus.rf_write = wr_q;
                bus.rf_read  = !wr_q;
                state_d      = wr_q ? RESP : WAIT;
            end
            WAIT: state_d = (bus.rf_done || timed_out) ? RESP : WAIT;
            default: begin
                bus.rsp_valid = NUM_REQ'(1) << owner;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            owner   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            rsp_to  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        owner  <= gidx;
                        wr_q   <= bus.req_write[gidx];
                        addr_q <= bus.req_addr[int'(gidx) * ADDR_W +: ADDR_W];
                        data_q <= bus.req_wdata[int'(gidx) * DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (wr_q) begin
                        rdata_q <= '0;
                        rsp_to  <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (bus.rf_done) begin
                        rdata_q <= bus.rf_read_data;
                        rsp_to  <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= DATA_W'(TIMEOUT_DATA);
                        rsp_to  <= 1'b1;
                    end
                end
                default: ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            endcase
        end
    end

    assign bus.rf_address    = addr_q;
    assign bus.rf_write_data = data_q;
    assign bus.rsp_rdata     = rdata_q;
    assign bus.rsp_timeout   = rsp_to;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed self-checking bench for regfile_arbiter (2 requesters, TIMEOUT 15).
module tb_regfile_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_arbiter_if #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8)) bus();

    regfile_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Register-file model: done is presented rf_lat cycles after the read strobe (0 = never).
    int         rf_lat  = 1;
    int         rf_cnt  = 0;
    logic [7:0] rf_data = 8'hAB;
    int         rd_pulses = 0, wr_pulses = 0, adj_hits = 0, both_hits = 0;
    logic       prev_rd = 1'b0;

    always @(posedge clk) begin
        #1;
        if (bus.rf_read) rd_pulses++;
        if (bus.rf_write) wr_pulses++;
        if (bus.rf_read && prev_rd) adj_hits++;
        if (bus.rf_read && bus.rf_write) both_hits++;
        prev_rd     = bus.rf_read;
        bus.rf_done = 1'b0;
        if (rst) rf_cnt = 0;
        else if (bus.rf_read) rf_cnt = rf_lat;
        else if (rf_cnt > 0) begin
            rf_cnt--;
            bus.rf_done = (rf_cnt == 0);
        end
        bus.rf_read_data = bus.rf_done ? rf_data : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b11;
        tick();
        tick();
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout, bus.rf_read,
             bus.rf_write, bus.rf_address, bus.rf_write_data} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rsp=%b rdata=%h to=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout, bus.rf_read,
                     bus.rf_write, bus.rf_address, bus.rf_write_data);
        end
        bus.req_valid = 2'b00;
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.req_ready, bus.rf_read, bus.rf_write, bus.rsp_valid} !== 6'd0) begin
            errors++;
            $display("FAIL idle_no_valid: got ready=%b rd=%b wr=%b rsp=%b, want 0",
                     bus.req_ready, bus.rf_read, bus.rf_write, bus.rsp_valid);
        end
    endtask

    task automatic test_single_read();
        int rd0;
        rf_lat  = 1;
        rf_data = 8'hAB;
        rd0 = rd_pulses;
        bus.req_write = 2'b00;
        bus.req_addr  = {8'd0, 8'd80};
        bus.req_valid = 2'b01;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL read_ready: got %b, want 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        checks++;
        if ({bus.rf_read, bus.rf_write, bus.rf_address} !== {1'b1, 1'b0, 8'd80}) begin
            errors++;
            $display("FAIL read_strobe: got rd=%b wr=%b addr=%0d, want rd=1 wr=0 addr=80",
                     bus.rf_read, bus.rf_write, bus.rf_address);
        end
        tick();
        checks++;
        if ({bus.rf_read, bus.rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL read_wait: got rd=%b rsp=%b, want 0 00", bus.rf_read, bus.rsp_valid);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout} !== {2'b01, 8'hAB, 1'b0}) begin
            errors++;
            $display("FAIL read_resp: got rsp=%b rdata=%h to=%b, want 01 ab 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_rdata} !== {2'b00, 8'hAB}) begin
            errors++;
            $display("FAIL read_hold: got rsp=%b rdata=%h, want 00 ab", bus.rsp_valid, bus.rsp_rdata);
        end
        checks++;
        if (rd_pulses - rd0 !== 1) begin
            errors++;
            $display("FAIL read_pulses: got %0d, want 1", rd_pulses - rd0);
        end
    endtask

    task automatic test_single_write();
        int wr0;
        wr0 = wr_pulses;
        bus.req_write = 2'b10;
        bus.req_addr  = {8'd12, 8'd0};
        bus.req_wdata = {8'h5A, 8'h00};
        bus.req_valid = 2'b10;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL write_ready: got %b, want 10", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        checks++;
        if ({bus.rf_write, bus.rf_read, bus.rf_address, bus.rf_write_data} !== {1'b1, 1'b0, 8'd12, 8'h5A}) begin
            errors++;
            $display("FAIL write_strobe: got wr=%b rd=%b addr=%0d wdata=%h, want 1 0 12 5a",
                     bus.rf_write, bus.rf_read, bus.rf_address, bus.rf_write_data);
        end
        tick();
        checks++;
        if ({bus.rf_write, bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout} !== {1'b0, 2'b10, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL write_resp: got wr=%b rsp=%b rdata=%h to=%b, want 0 10 00 0",
                     bus.rf_write, bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 4'b0000 || wr_pulses - wr0 !== 1) begin
            errors++;
            $display("FAIL write_after: got rsp=%b ready=%b pulses=%0d, want 00 00 1",
                     bus.rsp_valid, bus.req_ready, wr_pulses - wr0);
        end
    endtask

    task automatic test_contention();
        int rd0, wr0, adj0, both0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rf_lat  = 1;
        rf_data = 8'h33;
        rd0 = rd_pulses; wr0 = wr_pulses; adj0 = adj_hits; both0 = both_hits;
        bus.req_write = 2'b10;
        bus.req_addr  = {8'h20, 8'h10};
        bus.req_wdata = {8'h77, 8'h00};
        bus.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] want;
            int n;
            want = (k % 2 == 1) ? 2'b10 : 2'b01;
            checks++;
            if (bus.req_ready !== want) begin
                errors++;
                $display("FAIL contention_grant%0d: got %b, want %b", k, bus.req_ready, want);
            end
            n = 0;
            do begin
                tick();
                n++;
            end while (bus.rsp_valid === 2'b00 && n < 10);
            checks++;
            if ({bus.rsp_valid, bus.rsp_rdata} !== {want, want[0] ? 8'h33 : 8'h00} || n != (want[0] ? 3 : 2)) begin
                errors++;
                $display("FAIL contention_resp%0d: got rsp=%b rdata=%h after %0d cycles, want %b %h after %0d",
                         k, bus.rsp_valid, bus.rsp_rdata, n, want, want[0] ? 8'h33 : 8'h00, want[0] ? 3 : 2);
            end
            if (k == 5) bus.req_valid = 2'b00;
            tick();
        end
        checks++;
        if (rd_pulses - rd0 !== 3 || wr_pulses - wr0 !== 3 || adj_hits !== adj0 || both_hits !== both0) begin
            errors++;
            $display("FAIL contention_strobes: got rd=%0d wr=%0d adj=%0d both=%0d, want 3 3 0 0",
                     rd_pulses - rd0, wr_pulses - wr0, adj_hits - adj0, both_hits - both0);
        end
    endtask

    task automatic test_fifo_safety();
        int rd0, adj0, seen, n, bad_data;
        rf_lat  = 1;
        rf_data = 8'h5C;
        rd0 = rd_pulses; adj0 = adj_hits;
        seen = 0; n = 0; bad_data = 0;
        bus.req_write = 2'b00;
        bus.req_addr  = {8'd0, 8'd24};
        bus.req_valid = 2'b01;
        while (seen < 8 && n < 200) begin
            tick();
            n++;
            if (bus.rsp_valid === 2'b01) begin
                seen++;
                if (bus.rsp_rdata !== 8'h5C) bad_data++;
                if (seen == 8) bus.req_valid = 2'b00;
            end
        end
        tick();
        checks++;
        if (seen !== 8 || n !== 31 || bad_data !== 0) begin
            errors++;
            $display("FAIL fifo_responses: got %0d responses in %0d cycles, %0d bad data, want 8 in 31, 0 bad",
                     seen, n, bad_data);
        end
        checks++;
        if (rd_pulses - rd0 !== 8) begin
            errors++;
            $display("FAIL fifo_pulses: got %0d rf_read pulses, want 8", rd_pulses - rd0);
        end
        checks++;
        if (adj_hits !== adj0) begin
            errors++;
            $display("FAIL fifo_adjacent: got %0d adjacent rf_read cycles, want 0", adj_hits - adj0);
        end
    endtask

    task automatic test_timeout();
        for (int t = 0; t < 2; t++) begin
            int n;
            logic [7:0] want_data;
            logic want_to;
            rf_lat    = (t == 0) ? 0 : 15;
            rf_data   = 8'hC7;
            want_data = (t == 0) ? 8'hEE : 8'hC7;
            want_to   = (t == 0);
            bus.req_write = 2'b00;
            bus.req_addr  = {8'd0, 8'd60};
            bus.req_valid = 2'b01;
            #1;
            tick();
            bus.req_valid = 2'b00;
            n = 1;
            while (bus.rsp_valid === 2'b00 && n < 40) begin
                tick();
                n++;
            end
            checks++;
            if (n !== 17) begin
                errors++;
                $display("FAIL timeout_latency%0d: got rsp after %0d cycles, want 17", t, n);
            end
            checks++;
            if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout} !== {2'b01, want_data, want_to}) begin
                errors++;
                $display("FAIL timeout_resp%0d: got rsp=%b rdata=%h to=%b, want 01 %h %b",
                         t, bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout, want_data, want_to);
            end
            tick();
            checks++;
            if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout} !== {2'b00, want_data, want_to}) begin
                errors++;
                $display("FAIL timeout_hold%0d: got rsp=%b rdata=%h to=%b, want 00 %h %b",
                         t, bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout, want_data, want_to);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        rf_lat = 0;
        bus.req_write = 2'b00;
        bus.req_addr  = {8'd60, 8'd0};
        bus.req_valid = 2'b10;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL midrst_grant: got %b, want 10", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout, bus.rf_read,
             bus.rf_write, bus.rf_address, bus.rf_write_data} !== 31'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got ready=%b rsp=%b rdata=%h to=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout, bus.rf_read,
                     bus.rf_write, bus.rf_address, bus.rf_write_data);
        end
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.rsp_valid !== 2'b00 || bus.rf_read !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midrst_stray: got %0d cycles with rsp_valid/rf_read after reset, want 0", stray);
        end
        bus.req_valid = 2'b11;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midrst_ptr: got %b, want 01", bus.req_ready);
        end
        bus.req_valid = 2'b00;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_fifo_safety();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the single register-file access port (read/write/address/write_data/done/read_data) between NUM_REQ requesters, e.g. the host command path and an autonomous config/patgen sequencer.
- Serialises transactions with round-robin arbitration and issues exactly one-cycle rf_read/rf_write pulses. Single pulses are required because register-file reads of FIFO addresses (24, 60) pop and count on every cycle read is high.
- Returns read data, or write completion, to the owning requester.
- Sits between the requesters and the register file, in the register file's clock domain.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 8, register address width
DATA_W, 8, register data width
TIMEOUT, 15, cycles to wait for rf_done before aborting a read (1..255)

Ports:
clk  in  1  system clock, same as the register file
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot command accept
rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
rsp_rdata  out  DATA_W  read data, shared; valid with rsp_valid
rsp_timeout  out  1  response is a timeout abort; valid with rsp_valid
rf_read  out  1  register-file read strobe
rf_write  out  1  register-file write strobe
rf_address  out  ADDR_W  register-file address
rf_write_data  out  DATA_W  register-file write data
rf_done  in  1  register-file read completion
rf_read_data  in  DATA_W  register-file read data, valid when rf_done=1

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.
- rst asserted mid-transaction:
  - the in-flight transaction is dropped and no rsp_valid is issued;
  - rf_read/rf_write are low from the next edge;
  - a write already strobed stays committed in the register file.
- States:
  - IDLE: req_ready = one-hot grant, combinational from req_valid and the pointer. The highest priority is ptr, then ptr+1, wrapping modulo NUM_REQ. A transfer happens when req_valid[i] and req_ready[i] are both high. On transfer, latch owner, write flag, address and data, then go to ISSUE. No valid inputs: req_ready = 0, stay in IDLE.
  - ISSUE: exactly one cycle. rf_address and rf_write_data are driven from the latch (held stable ISSUE through RESP). rf_write = latched write flag, rf_read = its inverse. Write goes to RESP; read goes to WAIT with the counter cleared.
  - WAIT: rf_read = 0 and the counter increments.
    - rf_done = 1: capture rf_read_data into rsp_rdata, rsp_timeout = 0, go to RESP.
    - rf_done = 0 with counter == TIMEOUT-1: rsp_rdata = 8'hEE (zero-extended/truncated to DATA_W), rsp_timeout = 1, go to RESP.
    - rf_done on the same cycle as the timeout: done wins.
  - RESP: rsp_valid[owner] = 1 for one cycle. For writes, rsp_rdata = 0 and rsp_timeout = 0. Pointer becomes (owner+1) mod NUM_REQ; go to IDLE.
- rf_done in any state other than WAIT is ignored.
- rsp_rdata and rsp_timeout hold their value until the next RESP.
- Latency, with the handshake at cycle N:
  - rf strobe at N+1;
  - write: rsp_valid at N+2, next grant possible at N+3;
  - read (register file answers at N+2): rsp_valid at N+3, next grant at N+4.
- Requesters must hold req_* stable while valid and not ready. Dropping valid before ready is allowed (no transfer occurs).
- No pipelining: at most one outstanding transaction.
- Starvation-free: any requester holding valid is granted within NUM_REQ transactions.

Decomposition:
- Package regfile_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), constant TIMEOUT_DATA = 8'hEE, default parameter constants.
- Sub-module rr_arbiter: combinational one-hot grant from the request vector and the pointer, parameterised by NUM_REQ.
- Top level: FSM, command/response latches, timeout counter.

Test Plan:
- Single read: req0 read addr 80 at N; model answers done=1, data 8'hAB at N+2 -> rf_read high for N+1 only, rsp_valid=2'b01 at N+3, rsp_rdata=8'hAB, rsp_timeout=0.
- Single write: req1 writes 8'h5A to addr 12 -> rf_write=1 for one cycle with rf_address=12 and rf_write_data=8'h5A; rsp_valid=2'b10 two cycles after the handshake.
- Contention: req0 and req1 both hold valid for 6 transactions from reset -> grants alternate 0,1,0,1,0,1; no double strobes; each response is routed to its owner.
- FIFO safety: 8 consecutive reads of addr 24 from req0 -> exactly 8 rf_read pulses, each 1 cycle wide, and rf_read is never high on adjacent cycles.
- Timeout: model never asserts done, TIMEOUT=15 -> rsp_valid 15 cycles after entering WAIT, rsp_rdata=8'hEE, rsp_timeout=1. Same stimulus but done on the 15th WAIT cycle -> real data returned, rsp_timeout=0.
- Reset mid-read: rst during WAIT -> all outputs 0 on the next edge, no rsp_valid, grant pointer back to 0 (req0 wins the next contention).
